// File: rtl/la_pwrseq.sv
// Power-domain sequencer: orders switch enable, clock enable, domain reset and
// isolation release on power-up, and the reverse on power-down, with ack timeout.
module la_pwrseq #(
    parameter     PROP    = "DEFAULT",
    parameter int CW      = 8,
    parameter int RST_DLY = 4,
    parameter int ISO_DLY = 2,
    parameter int ACK_TMO = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic pwr_req,
    input  logic pwr_ack,
    output logic pwr_en,
    output logic clk_en,
    output logic dom_reset,
    output logic iso,
    output logic pwr_on,
    output logic busy,
    output logic err
);

    localparam int CNT_MAX = (1 << CW) - 1;

    if (RST_DLY < 1 || RST_DLY > CNT_MAX) begin : g_bad_rst_dly
        $error("la_pwrseq: RST_DLY out of range for CW");
    end
    if (ISO_DLY < 1 || ISO_DLY > CNT_MAX) begin : g_bad_iso_dly
        $error("la_pwrseq: ISO_DLY out of range for CW");
    end
    if (ACK_TMO < 1 || ACK_TMO > CNT_MAX) begin : g_bad_ack_tmo
        $error("la_pwrseq: ACK_TMO out of range for CW");
    end
    if (PROP == 0) begin : g_bad_prop
        $error("la_pwrseq: PROP selector must be non-empty");
    end

    // An N-cycle wait loads N-1, so the exit edge is the one that sees zero.
    localparam logic [CW-1:0] RST_LD = CW'(RST_DLY - 1);
    localparam logic [CW-1:0] ISO_LD = CW'(ISO_DLY - 1);
    localparam logic [CW-1:0] TMO_LD = CW'(ACK_TMO - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_PWRUP,
        S_CLKON,
        S_RELRST,
        S_ON,
        S_ISOL,
        S_STOP,
        S_PWRDN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          ack_s1_q, ack_s_q;
    logic          pwr_en_q, clk_en_q, dom_reset_q, iso_q, pwr_on_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_OFF: begin
                if (pwr_req) begin
                    state_d = S_PWRUP;
                    cnt_d   = TMO_LD;
                    err_d   = 1'b0;
                end
            end
            S_PWRUP: begin
                if (ack_s_q) begin
                    state_d = S_CLKON;
                    cnt_d   = RST_LD;
                end else if (cnt_q == '0) begin
                    state_d = S_PWRDN;
                    cnt_d   = TMO_LD;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CLKON: begin
                if (cnt_q == '0) begin
                    state_d = S_RELRST;
                    cnt_d   = ISO_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RELRST: begin
                if (cnt_q == '0) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ON: begin
                if (!pwr_req) begin
                    state_d = S_ISOL;
                    cnt_d   = ISO_LD;
                end
            end
            S_ISOL: begin
                if (cnt_q == '0) begin
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                state_d = S_PWRDN;
                cnt_d   = TMO_LD;
            end
            S_PWRDN: begin
                if (!ack_s_q) begin
                    state_d = S_OFF;
                end else if (cnt_q == '0) begin
                    state_d = S_OFF;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_s1_q    <= 1'b0;
            ack_s_q     <= 1'b0;
            state_q     <= S_OFF;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            pwr_en_q    <= 1'b0;
            clk_en_q    <= 1'b0;
            dom_reset_q <= 1'b1;
            iso_q       <= 1'b1;
            pwr_on_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_s1_q    <= pwr_ack;
            ack_s_q     <= ack_s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            pwr_en_q    <= (state_d != S_OFF) && (state_d != S_PWRDN);
            clk_en_q    <= state_d inside {S_CLKON, S_RELRST, S_ON, S_ISOL};
            dom_reset_q <= !(state_d inside {S_RELRST, S_ON, S_ISOL});
            iso_q       <= (state_d != S_ON);
            pwr_on_q    <= (state_d == S_ON);
            busy_q      <= !(state_d inside {S_OFF, S_ON});
        end
    end

    assign pwr_en    = pwr_en_q;
    assign clk_en    = clk_en_q;
    assign dom_reset = dom_reset_q;
    assign iso       = iso_q;
    assign pwr_on    = pwr_on_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_la_pwrseq.sv
// Bench for la_pwrseq: directed power-up/down scenarios plus randomized request,
// switch-ack and reset activity, checked against a phase/residency table model.
module tb_la_pwrseq;

    localparam int CW      = 8;
    localparam int RST_DLY = 4;
    localparam int ISO_DLY = 2;
    localparam int ACK_TMO = 100;

    localparam int P_OFF = 0, P_PWRUP = 1, P_CLKON = 2, P_RELRST = 3;
    localparam int P_ON  = 4, P_ISOL  = 5, P_STOP  = 6, P_PWRDN  = 7;

    // Per phase: {pwr_en, clk_en, dom_reset, iso}, residency in cycles, fixed successor.
    localparam logic [3:0] PH_OUT [8] = '{4'b0011, 4'b1011, 4'b1111, 4'b1101,
                                          4'b1100, 4'b1101, 4'b1011, 4'b0011};
    localparam int         PH_DLY [8] = '{0, ACK_TMO, RST_DLY, ISO_DLY, 0, ISO_DLY, 1, ACK_TMO};
    localparam int         PH_NXT [8] = '{P_OFF, P_OFF, P_RELRST, P_ON, P_ON, P_STOP, P_PWRDN, P_OFF};

    logic clk = 1'b0;
    logic reset, pwr_req, pwr_ack;
    logic pwr_en, clk_en, dom_reset, iso, pwr_on, busy, err;

    int total = 0;
    int bad   = 0;

    int   m_ph, m_left;
    bit   m_err, m_s1, m_s2;
    int   ack_mode, ack_lag;
    logic [7:0] en_hist;

    always #5 clk = ~clk;

    la_pwrseq #(
        .PROP   ("DEFAULT"),
        .CW     (CW),
        .RST_DLY(RST_DLY),
        .ISO_DLY(ISO_DLY),
        .ACK_TMO(ACK_TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pwr_req  (pwr_req),
        .pwr_ack  (pwr_ack),
        .pwr_en   (pwr_en),
        .clk_en   (clk_en),
        .dom_reset(dom_reset),
        .iso      (iso),
        .pwr_on   (pwr_on),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph   = P_OFF;
        m_left = 0;
        m_err  = 1'b0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
    endtask

    task automatic enter(input int p);
        m_ph   = p;
        m_left = PH_DLY[p];
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        bit up;
        if (reset) begin
            model_reset();
            return;
        end
        up = (m_ph == P_PWRUP);
        case (m_ph)
            P_OFF: if (pwr_req) begin
                m_err = 1'b0;
                enter(P_PWRUP);
            end
            P_ON: if (!pwr_req) enter(P_ISOL);
            P_PWRUP, P_PWRDN: begin
                if (m_s2 == up) begin
                    enter(up ? P_CLKON : P_OFF);
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_err = 1'b1;
                        enter(up ? P_PWRDN : P_OFF);
                    end
                end
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) enter(PH_NXT[m_ph]);
            end
        endcase
        m_s2 = m_s1;
        m_s1 = pwr_ack;
    endtask

    task automatic check_inv(input string tag);
        logic ok;
        ok = iso || (clk_en && pwr_en && !dom_reset);
        assert (ok) else $error("iso released while domain not fully up");
        chk(tag, ok, 1'b1);
    endtask

    task automatic compare();
        chk("outs", {pwr_en, clk_en, dom_reset, iso}, PH_OUT[m_ph]);
        chk("pwr_on", pwr_on, m_ph == P_ON);
        chk("busy", busy, (m_ph != P_OFF) && (m_ph != P_ON));
        chk("err", err, m_err);
        check_inv("inv");
    endtask

    // Switch network stand-in: ack follows pwr_en with a lag, or is stuck.
    task automatic drive_ack();
        en_hist = {en_hist[6:0], pwr_en};
        case (ack_mode)
            1:       pwr_ack = 1'b0;
            2:       pwr_ack = 1'b1;
            default: pwr_ack = en_hist[ack_lag];
        endcase
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
        drive_ack();
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return pwr_on;
            1:       return !busy && !pwr_en && !pwr_on;
            2:       return clk_en && dom_reset;
            3:       return clk_en && !dom_reset && iso;
            default: return err;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int max, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < max) begin
            cyc();
            n++;
            hit = cond(sel);
        end
        chk(tag, hit, 1'b1);
    endtask

    initial begin
        int n, n_clk;
        reset    = 1'b1;
        pwr_req  = 1'b0;
        pwr_ack  = 1'b0;
        ack_mode = 0;
        ack_lag  = 2;
        en_hist  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_outs", {pwr_en, clk_en, dom_reset, iso}, 4'b0011);
        chk("rst_flags", {pwr_on, busy, err}, 3'b000);
        reset = 1'b0;

        // Idle in OFF with no request.
        repeat (20) cyc();
        chk("idle_off", {pwr_en, busy}, 2'b00);

        // Power-up with ack arriving 3 cycles after pwr_en.
        pwr_req = 1'b1;
        wait_for("t2_on", 0, 200, n);
        chk("t2_lat", n, 1 + 3 + 2 + RST_DLY + ISO_DLY);
        repeat (5) cyc();

        // Power-down from ON.
        pwr_req = 1'b0;
        n_clk   = 0;
        n       = 0;
        while (n < 300 && !cond(1)) begin
            cyc();
            n++;
            if (n_clk == 0 && !clk_en) n_clk = n;
        end
        chk("t3_off", cond(1), 1'b1);
        chk("t3_clkoff", n_clk, 1 + ISO_DLY);

        // Dead switch: ack never comes.
        ack_mode = 1;
        pwr_req  = 1'b1;
        wait_for("t4_err", 4, 300, n);
        chk("t4_tmo", n, ACK_TMO + 1);
        chk("t4_pwren", pwr_en, 1'b0);
        cyc();
        chk("t4_offerr", {busy, err}, 2'b01);
        cyc();
        chk("t4_clr", {pwr_en, err}, 2'b10);
        ack_mode = 0;
        ack_lag  = 1;
        wait_for("t4_on", 0, 300, n);
        pwr_req = 1'b0;
        wait_for("t4_down", 1, 300, n);

        // Request dropped during CLKON still completes power-up first.
        pwr_req = 1'b1;
        wait_for("t5_clkon", 2, 300, n);
        pwr_req = 1'b0;
        wait_for("t5_on", 0, 300, n);
        wait_for("t5_off", 1, 300, n);

        // Reset in RELRST forces the OFF output values immediately.
        pwr_req = 1'b1;
        wait_for("t6_relrst", 3, 300, n);
        #2 reset = 1'b1;
        #1;
        chk("t6_outs", {pwr_en, clk_en, dom_reset, iso}, 4'b0011);
        chk("t6_flags", {pwr_on, busy}, 2'b00);
        check_inv("t6_inv");
        cyc();
        cyc();
        reset = 1'b0;

        // Randomized requests, switch behaviour and reset pulses.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) pwr_req = ~pwr_req;
            if ($urandom_range(0, 299) == 0) begin
                n        = $urandom_range(0, 5);
                ack_mode = (n < 4) ? 0 : n - 3;
                ack_lag  = $urandom_range(0, 5);
            end
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 999) == 0) reset = 1'b1;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
